// File: rtl/link_seq_pkg.sv
// link_seq_pkg: shared types and defaults for the link sequencer.
//   state_e        - frame controller states
//   popcount()     - number of set bits in a 32-bit word
//   *_D constants  - default parameter values for the sequencer
package link_seq_pkg;

    localparam int unsigned FRAME_BITS_D  = 7;
    localparam int unsigned TAIL_BITS_D   = 2;
    localparam int unsigned BIT_DIV_D     = 200;
    localparam int unsigned DEC_TIMEOUT_D = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_DRAIN,
        ST_DONE
    } state_e;

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            n = n + {31'b0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/link_sequencer_strobe_gen.sv
// strobe_gen: single-clock bit/symbol strobe generator.
//   clk, rst_n  - clock, asynchronous active-low reset
//   clr_i       - force the divider to 0 (frame start)
//   en_i        - divider runs while high
//   bit_stb_o   - one-cycle pulse when div_cnt == BIT_DIV-1
//   sym_stb_o   - one-cycle pulse at div_cnt == BIT_DIV/2-1 and BIT_DIV-1
module strobe_gen
    import link_seq_pkg::*;
#(
    parameter int unsigned BIT_DIV = BIT_DIV_D
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic bit_stb_o,
    output logic sym_stb_o
);

    localparam int unsigned DW = $clog2(BIT_DIV);
    localparam logic [DW-1:0] LAST = DW'(BIT_DIV - 1);
    localparam logic [DW-1:0] HALF = DW'(BIT_DIV / 2 - 1);

    logic [DW-1:0] div_q, div_d;
    logic          bit_q, sym_q;

    always_comb begin
        div_d = div_q;
        if (clr_i) begin
            div_d = '0;
        end else if (en_i) begin
            div_d = (div_q == LAST) ? '0 : div_q + 1'b1;
        end
    end

    // Strobes are decoded from the next divider value so they come straight
    // out of flops and line up with the cycle in which div_cnt holds the value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            bit_q <= 1'b0;
            sym_q <= 1'b0;
        end else begin
            div_q <= div_d;
            bit_q <= en_i && (div_d == LAST);
            sym_q <= en_i && ((div_d == LAST) || (div_d == HALF));
        end
    end

    assign bit_stb_o = bit_q;
    assign sym_stb_o = sym_q;

endmodule

// File: rtl/link_sequencer.sv
// link_sequencer: frame-level controller for the convolutional-coding link.
// Loads a frame (plus zero tail) into the encoder one bit per bit strobe,
// releases the decoder reset, gathers decoded bits and reports the frame.
//   clk, rst_n          - clock, asynchronous active-low reset
//   start, frame_in     - frame request (IDLE only) and message, MSB first
//   bit_stb, sym_stb    - bit / coded-symbol strobes
//   enc_x, enc_en       - encoder input bit and its qualifier
//   dec_rst_n           - decoder reset, released for SEND/DRAIN
//   dec_ready, dec_c    - decoder output valid / decoded bit
//   busy, done          - activity flag, one-cycle completion pulse
//   frame_out, err_cnt  - received frame, Hamming distance vs sent frame
//   timeout             - decoder did not deliver a full frame in time
// Optional feature: define LINK_SEQ_BER_EN to build the bit-error counter;
// without it err_cnt is tied to 0.
module link_sequencer
    import link_seq_pkg::*;
#(
    parameter int unsigned FRAME_BITS  = FRAME_BITS_D,
    parameter int unsigned TAIL_BITS   = TAIL_BITS_D,
    parameter int unsigned BIT_DIV     = BIT_DIV_D,
    parameter int unsigned DEC_TIMEOUT = DEC_TIMEOUT_D
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [FRAME_BITS-1:0]           frame_in,
    output logic                            bit_stb,
    output logic                            sym_stb,
    output logic                            enc_x,
    output logic                            enc_en,
    output logic                            dec_rst_n,
    input  logic                            dec_ready,
    input  logic                            dec_c,
    output logic                            busy,
    output logic                            done,
    output logic [FRAME_BITS-1:0]           frame_out,
    output logic [$clog2(FRAME_BITS+1)-1:0] err_cnt,
    output logic                            timeout
);

    localparam int unsigned TXW = FRAME_BITS + TAIL_BITS;
    localparam int unsigned BCW = $clog2(TXW + 1);
    localparam int unsigned RCW = $clog2(FRAME_BITS + 1);
    localparam int unsigned WCW = $clog2(DEC_TIMEOUT + 1);

    state_e                state_q;
    logic [TXW-1:0]        tx_q;
    logic [BCW-1:0]        bit_cnt_q;
    logic [FRAME_BITS-1:0] rx_q, rx_d;
    logic [RCW-1:0]        rx_cnt_q, rx_cnt_d;
    logic [WCW-1:0]        wait_cnt_q;
    logic                  enc_en_q, dec_rst_n_q, busy_q, done_q, timeout_q;
    logic [FRAME_BITS-1:0] frame_out_q;

    logic running, capture, rx_full, timed_out, finish, accept;

    strobe_gen #(
        .BIT_DIV(BIT_DIV)
    ) u_strobe (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (accept),
        .en_i     (running),
        .bit_stb_o(bit_stb),
        .sym_stb_o(sym_stb)
    );

    always_comb begin
        accept    = (state_q == ST_IDLE) && start;
        running   = (state_q == ST_SEND) || (state_q == ST_DRAIN);
        capture   = running && bit_stb && dec_ready && (rx_cnt_q != RCW'(FRAME_BITS));
        rx_d      = capture ? {rx_q[FRAME_BITS-2:0], dec_c} : rx_q;
        rx_cnt_d  = capture ? rx_cnt_q + 1'b1 : rx_cnt_q;
        rx_full   = capture && (rx_cnt_d == RCW'(FRAME_BITS));
        timed_out = (state_q == ST_DRAIN) && bit_stb && !rx_full &&
                    (wait_cnt_q == WCW'(DEC_TIMEOUT - 1));
        finish    = rx_full || timed_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            tx_q        <= '0;
            bit_cnt_q   <= '0;
            rx_q        <= '0;
            rx_cnt_q    <= '0;
            wait_cnt_q  <= '0;
            enc_en_q    <= 1'b0;
            dec_rst_n_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            frame_out_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        tx_q        <= {frame_in, {TAIL_BITS{1'b0}}};
                        bit_cnt_q   <= '0;
                        rx_q        <= '0;
                        rx_cnt_q    <= '0;
                        wait_cnt_q  <= '0;
                        enc_en_q    <= 1'b1;
                        dec_rst_n_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    rx_q     <= rx_d;
                    rx_cnt_q <= rx_cnt_d;
                    if (bit_stb) begin
                        tx_q      <= tx_q << 1;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BCW'(TXW - 1)) begin
                            enc_en_q <= 1'b0;
                            state_q  <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    rx_q     <= rx_d;
                    rx_cnt_q <= rx_cnt_d;
                    if (bit_stb) begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
            // Completion overrides the per-state updates above; the report
            // uses rx_d so the bit captured on this strobe is included.
            if (finish) begin
                state_q     <= ST_DONE;
                done_q      <= 1'b1;
                enc_en_q    <= 1'b0;
                dec_rst_n_q <= 1'b0;
                frame_out_q <= rx_d;
                timeout_q   <= timed_out;
            end
        end
    end

`ifdef LINK_SEQ_BER_EN
    logic [FRAME_BITS-1:0] tx_ref_q;
    logic [RCW-1:0]        err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_ref_q <= '0;
            err_q    <= '0;
        end else begin
            if (accept) begin
                tx_ref_q <= frame_in;
            end
            if (finish) begin
                err_q <= RCW'(popcount(32'(rx_d ^ tx_ref_q)));
            end
        end
    end

    assign err_cnt = err_q;
`else
    assign err_cnt = '0;
`endif

    assign enc_x     = tx_q[TXW-1];
    assign enc_en    = enc_en_q;
    assign dec_rst_n = dec_rst_n_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign frame_out = frame_out_q;
    assign timeout   = timeout_q;

endmodule
